// File: rtl/uart_frame_pkg.sv
// Shared types for the UART frame controller: FSM encoding, discard causes
// and the default frame start marker.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_LEN    = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_COMMIT = 3'd5,
    ST_OK     = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CHK     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_ctrl_frame_buf.sv
// Payload store for one frame: MAX_LEN bytes, one write port and one
// combinational read port sharing the frame index.
module frame_buf #(
  parameter int MAX_LEN = 8
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       we_i,
  input  logic [3:0] idx_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [MAX_LEN];

  // Index compared per entry so a 4-bit index never addresses past MAX_LEN.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (idx_i == 4'(i)) mem_q[i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (idx_i == 4'(i)) rdata_o = mem_q[i];
    end
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Turns the UART receiver byte stream into checksummed register-write bursts.
// Handshake: a byte is taken on each rising edge of rx_avail; wr_en is a
// one-cycle-per-write strobe with no back-pressure from the register bus.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int         MAX_LEN   = 8,
  parameter int         TIMEOUT   = 23440
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       rx_avail,
  input  logic [7:0] rx_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy,
  output state_e     dbg_state_o
);

  // Expiry fires one cycle early so frame_err lands exactly TIMEOUT cycles
  // after the last accepted strobe.
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 2);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  state_e      state_q;
  logic        avail_q;
  logic        pend_v_q, pend_v_d;
  logic [7:0]  pend_b_q, pend_b_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  base_q, chk_q;
  logic [3:0]  len_q, idx_q;
  logic        wr_en_q, frame_ok_q, frame_err_q;
  logic [7:0]  wr_addr_q, wr_data_q;
  logic [1:0]  err_code_q;

  logic        stb, rx_state, timed, take, tmo, buf_we;
  logic [7:0]  byte_in, rd_data;

  assign stb      = rx_avail & ~avail_q;
  assign rx_state = state_q inside {ST_IDLE, ST_ADDR, ST_LEN, ST_DATA, ST_CHK};
  assign timed    = state_q inside {ST_ADDR, ST_LEN, ST_DATA, ST_CHK};
  assign take     = rx_state & (pend_v_q | stb);
  assign byte_in  = pend_v_q ? pend_b_q : rx_data;
  assign tmo      = timed & ~take & (cnt_q == TMO_LAST);
  assign buf_we   = take & (state_q == ST_DATA);

  frame_buf #(.MAX_LEN(MAX_LEN)) u_buf (
    .clock   (clock),
    .rst     (rst),
    .we_i    (buf_we),
    .idx_i   (idx_q),
    .wdata_i (byte_in),
    .rdata_o (rd_data)
  );

  // Pending slot drains first; a strobe that cannot be taken now lands here.
  always_comb begin
    pend_v_d = pend_v_q;
    pend_b_d = pend_b_q;
    if (stb && (!rx_state || pend_v_q)) begin
      pend_v_d = 1'b1;
      pend_b_d = rx_data;
    end else if (take) begin
      pend_v_d = 1'b0;
    end
    cnt_d = '0;
    if (timed && !take) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      avail_q  <= 1'b1;
      pend_v_q <= 1'b0;
      pend_b_q <= '0;
      cnt_q    <= '0;
    end else begin
      avail_q  <= rx_avail;
      pend_v_q <= pend_v_d;
      pend_b_q <= pend_b_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      chk_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (take && byte_in == SYNC_BYTE) state_q <= ST_ADDR;
        end
        ST_ADDR: begin
          if (take) begin
            base_q  <= byte_in;
            chk_q   <= byte_in;
            state_q <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (take) begin
            if (byte_in != 8'd0 && byte_in <= MAX_LEN_B) begin
              len_q   <= byte_in[3:0];
              chk_q   <= chk_q ^ byte_in;
              idx_q   <= '0;
              state_q <= ST_DATA;
            end else begin
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_LEN;
              state_q     <= ST_ERR;
            end
          end
        end
        ST_DATA: begin
          if (take) begin
            chk_q <= chk_q ^ byte_in;
            if (idx_q == len_q - 4'd1) begin
              idx_q   <= '0;
              state_q <= ST_CHK;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        ST_CHK: begin
          if (take) begin
            if (byte_in == chk_q) begin
              // First write is presented in the cycle right after the strobe.
              wr_en_q   <= 1'b1;
              wr_addr_q <= base_q;
              wr_data_q <= rd_data;
              idx_q     <= 4'd1;
              state_q   <= ST_COMMIT;
            end else begin
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_CHK;
              state_q     <= ST_ERR;
            end
          end
        end
        ST_COMMIT: begin
          if (idx_q == len_q) begin
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            frame_ok_q <= 1'b1;
            state_q    <= ST_OK;
          end else begin
            wr_addr_q <= base_q + {4'd0, idx_q};
            wr_data_q <= rd_data;
            idx_q     <= idx_q + 4'd1;
          end
        end
        ST_OK: begin
          frame_ok_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
        ST_ERR: begin
          frame_err_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (tmo) begin
        frame_err_q <= 1'b1;
        err_code_q  <= ERR_TIMEOUT;
        state_q     <= ST_ERR;
      end
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_ok    = frame_ok_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule
